ifu_pc_seq: RTL
===============

Name: ifu_pc_seq

Overview:
- Instruction-fetch / next-PC sequencer for the multi-cycle MIPS core.
- Holds the PC and fetches the instruction word over a req/ready handshake, then presents the latched IR (op/func/branop fields) to the control decoder.
- When execute signals commit, consumes the decoder's Branch/Jump codes plus register operands and computes the next PC.
- Also supplies the link value for jal/jalr and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- Clk  in  1  core clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, level, held until ready.
- imem_addr  out  32  fetch address, equals pc while imem_req is high.
- imem_rdata  in  32  instruction word, valid when imem_ready is high.
- imem_ready  in  1  fetch completes this cycle.
- instr  out  32  latched instruction register.
- instr_valid  out  1  instr holds the current instruction (HOLD state).
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc+4, also the link value for jal/jalr.
- commit  in  1  execute/writeback of the current instruction done.
- Branch  in  3  decoder code: 000 none, 001 beq, 010 bne, 011 bgez, 100 bgtz, 101 blez, 110 bltz, 111 reserved.
- Jump  in  2  decoder code: 00 none, 01 j/jal, 10 jr/jalr, 11 reserved.
- rs_val  in  32  GPR[rs].
- rt_val  in  32  GPR[rt].
- redirect  out  1  one-cycle pulse: the last commit changed flow.
- pc_misalign  out  1  sticky: a jr target had nonzero bits [1:0].
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, Rst_n=0) forces:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
  - redirect=0, pc_misalign=0, instret=0, state=IDLE.
- FSM states IDLE, FETCH, HOLD.
  - IDLE: exactly one cycle after reset release, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready=1, at the same edge: instr<=imem_rdata, instr_valid<=1, go to HOLD. Ready in the first FETCH cycle gives 1-cycle fetch latency. No ready means stay in FETCH, request held.
  - HOLD: instr stable and instr_valid=1. On commit=1: pc<=next_pc, instret<=instret+1, instr_valid<=0, go to FETCH.
- commit is ignored in IDLE and FETCH. imem_ready is ignored outside FETCH.
- next_pc, Jump has priority over Branch:
  - Jump=01: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Jump=10: {rs_val[31:2], 2'b00}. If rs_val[1:0]!=0, set pc_misalign (sticky until reset).
  - Jump=11: treated as 00.
  - Otherwise, branch taken if: beq rs==rt; bne rs!=rt; bgez rs[31]==0; bgtz signed rs>0; blez signed rs<=0; bltz rs[31]==1.
  - Taken target = pc_plus4 + (sext(instr[15:0])<<2), mod 2^32. Not taken, Branch=000 or Branch=111 gives pc_plus4.
- No delay slot.
- pc_plus4 = pc+4 mod 2^32 (32'hFFFF_FFFC wraps to 0). Branch-target overflow also wraps.
- redirect=1 in the cycle after a commit whose next_pc != pc_plus4; otherwise 0.
- instret wraps at 2^CNT_W.
- Reset mid-fetch: imem_req drops immediately. A late ready after reset release is ignored (state is IDLE).
- All outputs are registered except imem_addr (=pc) and pc_plus4 (combinational from pc).

Decomposition:
- Shared package cpu_defs holds:
  - Branch code constants (BR_NONE, BR_EQ, BR_NE, BR_GEZ, BR_GTZ, BR_LEZ, BR_LTZ).
  - Jump code constants (JP_NONE, JP_J, JP_JR).
  - FSM state encodings.
  - RESET_PC default.
  - The same constants used by the control decoder.
- One sub-module, ifu_br_cond: combinational condition evaluator taking Branch, rs_val, rt_val and producing taken.

Test Plan:
- Reset then ready on first FETCH cycle with rdata=32'h3C01_1234 -> imem_addr=32'h3000, instr=32'h3C01_1234 and instr_valid=1 the next cycle; commit with Branch=0, Jump=0 -> pc=32'h3004, instret=1, redirect=0.
- Ready delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles; commit pulsed during FETCH has no effect.
- pc=32'h3008, instr[15:0]=16'hFFFE, Branch=001, rs=rt=5 -> pc=32'h3004, redirect=1. Same case with rt=6 -> pc=32'h300C.
- Branch=100 (bgtz), rs=0 -> not taken. rs=32'h8000_0000 with Branch=110 (bltz) -> taken. rs=0 with Branch=101 (blez) -> taken.
- Jump=10, rs_val=32'h0000_4003 -> pc=32'h4000, pc_misalign=1 and stays set. Jump=01 with Branch=001 both active -> jump target wins.
- Rst_n asserted during FETCH -> imem_req=0 immediately; ready asserted in the first post-reset cycle is ignored; pc=RESET_PC.

Source files
------------

// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Constants shared by the fetch sequencer and the control
//                decoder: branch/jump codes, fetch FSM state encodings and
//                the default reset PC.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    // Branch condition codes produced by the control decoder
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_GEZ  = 3'b011;
    localparam logic [2:0] BR_GTZ  = 3'b100;
    localparam logic [2:0] BR_LEZ  = 3'b101;
    localparam logic [2:0] BR_LTZ  = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    // Jump codes produced by the control decoder
    localparam logic [1:0] JP_NONE = 2'b00;
    localparam logic [1:0] JP_J    = 2'b01;
    localparam logic [1:0] JP_JR   = 2'b10;
    localparam logic [1:0] JP_RSVD = 2'b11;

    // Fetch sequencer state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Default PC after reset
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/ifu_br_cond.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_br_cond
//  Description : Combinational branch-condition evaluator. Decides whether
//                the decoded branch is taken from the GPR operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_br_cond
    import cpu_defs::*;
(
    input  logic [2:0]  branch_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output logic        taken_o
);

    logic w_rs_zero;
    logic w_rs_neg;

    assign w_rs_zero = (rs_val_i == 32'd0);
    assign w_rs_neg  = rs_val_i[31];

    // Evaluate the condition; reserved and none codes never take
    always_comb begin
        taken_o = 1'b0;
        case (branch_i)
            BR_EQ:   taken_o = (rs_val_i == rt_val_i);
            BR_NE:   taken_o = (rs_val_i != rt_val_i);
            BR_GEZ:  taken_o = !w_rs_neg;
            BR_GTZ:  taken_o = !w_rs_neg && !w_rs_zero;
            BR_LEZ:  taken_o = w_rs_neg || w_rs_zero;
            BR_LTZ:  taken_o = w_rs_neg;
            default: taken_o = 1'b0;
        endcase
    end

endmodule : ifu_br_cond
`default_nettype wire

// File: rtl/ifu_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_pc_seq
//  Description : Instruction-fetch / next-PC sequencer for the multi-cycle
//                MIPS core. Fetches over a req/ready handshake, holds the IR
//                for the decoder, and computes the next PC on commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_seq
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    input  logic             commit,
    input  logic [2:0]       Branch,
    input  logic [1:0]       Jump,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic             redirect,
    output logic             pc_misalign,
    output logic [CNT_W-1:0] instret
);

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic             redirect_q;
    logic             misalign_q;
    logic [CNT_W-1:0] instret_q;

    logic             w_fetch_done;
    logic             w_retire;
    logic             w_taken;
    logic [31:0]      w_br_off;
    logic [31:0]      w_next_pc;
    logic             w_jr_misalign;

    assign w_fetch_done = (state_q == ST_FETCH) && imem_ready;
    assign w_retire     = (state_q == ST_HOLD) && commit;

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;

    ifu_br_cond u_br_cond (
        .branch_i (Branch),
        .rs_val_i (rs_val),
        .rt_val_i (rt_val),
        .taken_o  (w_taken)
    );

    // Sign-extended word offset of the branch immediate
    assign w_br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    // Next PC: jumps override branches; reserved jump code behaves as none
    always_comb begin
        w_next_pc = pc_plus4;
        if (Jump == JP_J) begin
            w_next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (Jump == JP_JR) begin
            w_next_pc = {rs_val[31:2], 2'b00};
        end else if (w_taken) begin
            w_next_pc = pc_plus4 + w_br_off;
        end
    end

    assign w_jr_misalign = (Jump == JP_JR) && (rs_val[1:0] != 2'b00);

    // FSM state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one idle cycle after reset, then fetch/hold loop
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ready) state_d = ST_HOLD;
            ST_HOLD:  if (commit)     state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded straight from the state register
    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        instr_valid = (state_q == ST_HOLD);
    end

    // Datapath: IR capture, PC update, retire count and status flags
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            redirect_q <= 1'b0;
            if (w_fetch_done) begin
                instr_q <= imem_rdata;
            end
            if (w_retire) begin
                pc_q       <= w_next_pc;
                instret_q  <= instret_q + 1'b1;
                redirect_q <= (w_next_pc != pc_plus4);
                if (w_jr_misalign) begin
                    misalign_q <= 1'b1;
                end
            end
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign redirect    = redirect_q;
    assign pc_misalign = misalign_q;
    assign instret     = instret_q;

endmodule : ifu_pc_seq
`default_nettype wire
